// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream writer for the instruction memory.
// Keeps the core in reset until a whole program has been written.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);
    localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

    state_e                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [31:0]           len_q, len_d;
    logic [31:0]           word_q, word_d;
    logic [31:0]           shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic        xfer;
    logic [31:0] shift_in;

    assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA);
    assign mem_we     = (state_q == S_WRITE);
    assign busy       = byte_ready || mem_we;
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign core_rst_n = done;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    // Little-endian assembly: each new byte enters at the top and
    // the first byte of a group ends up in bits [7:0].
    assign xfer     = byte_valid && byte_ready;
    assign shift_in = {byte_data, shift_q[31:8]};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        word_d  = word_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN;
                    idx_d   = '0;
                    len_d   = '0;
                    word_d  = '0;
                    shift_d = '0;
                    addr_d  = BASE_ADDR;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    shift_d = shift_in;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        len_d = shift_in;
                        if (shift_in == '0 || shift_in > DEPTH) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    shift_d = shift_in;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        wdata_d = shift_in;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    word_d = word_q + 32'd1;
                    addr_d = addr_q + ADDR_STEP;
                    if (word_q + 32'd1 == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            word_q  <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            word_q  <= word_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized stream loads against a write-list model,
// run on a 32-bit instance and a lockstep 8-bit wrapping instance.
module tb_imem_loader;

    localparam logic [31:0] BASE_A = 32'h0000_0100;
    localparam logic [7:0]  BASE_B = 8'hF8;
    localparam int          DEPTH  = 256;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        mem_ready = 1'b1;

    logic        br_a, we_a, crn_a, busy_a, done_a, err_a;
    logic [31:0] addr_a, wd_a;
    logic        br_b, we_b, crn_b, busy_b, done_b, err_b;
    logic [7:0]  addr_b;
    logic [31:0] wd_b;

    int          chk = 0;
    int          pass = 0;
    wr_t         exp_a[$];
    wr_t         exp_b[$];
    int          wr_a = 0;
    int          wr_b = 0;
    logic [31:0] last_a_addr = '0;
    logic [31:0] last_a_data = '0;
    logic [7:0]  last_b_addr = '0;
    int          rdy_mode = 0;
    bit          noise = 1'b0;
    logic [31:0] prog[$];

    imem_loader #(
        .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE_A)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(br_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wd_a), .mem_ready(mem_ready),
        .core_rst_n(crn_a), .busy(busy_a), .done(done_a),
        .error(err_a)
    );

    imem_loader #(
        .ADDR_WIDTH(8), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE_B)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(br_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wd_b), .mem_ready(mem_ready),
        .core_rst_n(crn_b), .busy(busy_b), .done(done_b),
        .error(err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        chk++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Compare process: every write against the expected list, plus
    // per-cycle status rules and hold-while-stalled.
    initial begin
        bit          sa, sb, ok;
        logic [31:0] pa_a, pd_a, pd_b;
        logic [7:0]  pa_b;
        wr_t         w;
        sa = 0; sb = 0;
        pa_a = '0; pd_a = '0; pd_b = '0; pa_b = '0;
        forever begin
            @(negedge clk);
            ok = (int'(busy_a) + int'(done_a) + int'(err_a) <= 1)
                 && (crn_a == done_a) && !(we_a && br_a)
                 && (!we_a || busy_a);
            check("status_a", 32'(ok), 1);
            ok = (int'(busy_b) + int'(done_b) + int'(err_b) <= 1)
                 && (crn_b == done_b) && !(we_b && br_b)
                 && (!we_b || busy_b);
            check("status_b", 32'(ok), 1);
            if (sa) begin
                check("hold_we_a", 32'(we_a), 1);
                check("hold_addr_a", addr_a, pa_a);
                check("hold_data_a", wd_a, pd_a);
            end
            if (sb) begin
                check("hold_addr_b", 32'(addr_b), 32'(pa_b));
                check("hold_data_b", wd_b, pd_b);
            end
            if (rst && we_a && mem_ready) begin
                wr_a++;
                last_a_addr = addr_a;
                last_a_data = wd_a;
                check("wr_a_expected", 32'(exp_a.size() > 0), 1);
                if (exp_a.size() > 0) begin
                    w = exp_a.pop_front();
                    check("wr_a_addr", addr_a, w.a);
                    check("wr_a_data", wd_a, w.d);
                end
            end
            if (rst && we_b && mem_ready) begin
                wr_b++;
                last_b_addr = addr_b;
                check("wr_b_expected", 32'(exp_b.size() > 0), 1);
                if (exp_b.size() > 0) begin
                    w = exp_b.pop_front();
                    check("wr_b_addr", 32'(addr_b), w.a);
                    check("wr_b_data", wd_b, w.d);
                end
            end
            sa = rst && we_a && !mem_ready;
            sb = rst && we_b && !mem_ready;
            pa_a = addr_a; pd_a = wd_a;
            pa_b = addr_b; pd_b = wd_b;
        end
    end

    // Memory-side responder: always ready, 3-cycle stall per write,
    // or random.
    initial begin
        int stall;
        stall = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: mem_ready = 1'b1;
                1: begin
                    if (we_a) begin
                        if (stall < 3) begin
                            mem_ready = 1'b0;
                            stall++;
                        end else begin
                            mem_ready = 1'b1;
                        end
                    end else begin
                        stall = 0;
                        mem_ready = 1'b0;
                    end
                end
                default: mem_ready = 1'($urandom_range(1, 0));
            endcase
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int t;
        bit acc;
        repeat ($urandom_range(maxgap, 0)) begin
            byte_valid = 1'b0;
            byte_data = 8'($urandom);
            if (noise) start = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data = b;
        t = 0;
        forever begin
            if (noise) start = 1'($urandom_range(1, 0));
            @(negedge clk);
            acc = br_a;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 100) begin
                check("byte_timeout", 32'(acc), 1);
                break;
            end
        end
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], maxgap);
    endtask

    task automatic load(input int n, input bit do_start,
                        input int maxgap, input bit timed);
        bit ok;
        int base_a, base_b, t;
        logic [7:0] ab;
        ok = (n >= 1) && (n <= DEPTH);
        base_a = wr_a;
        base_b = wr_b;
        if (do_start) pulse_start();
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                ab = BASE_B + 8'(4 * i);
                exp_a.push_back('{a: BASE_A + 32'(4 * i), d: prog[i]});
                exp_b.push_back('{a: 32'(ab), d: prog[i]});
            end
        end
        send_word(32'(n), maxgap);
        if (!ok) begin
            @(negedge clk);
            check("len_err_a", 32'(err_a), 1);
            check("len_err_b", 32'(err_b), 1);
            check("len_err_busy", 32'(busy_a), 0);
            check("len_err_nowr", 32'(wr_a - base_a), 0);
            @(posedge clk);
            #1;
            return;
        end
        for (int i = 0; i < n; i++) send_word(prog[i], maxgap);
        if (timed) begin
            @(negedge clk);
            check("lat_we", 32'(we_a), 1);
            @(posedge clk);
            #1;
        end
        t = 0;
        forever begin
            @(negedge clk);
            if (done_a || err_a || t >= 5000) break;
            t++;
        end
        if (timed) check("lat_done", 32'(t), 0);
        check("done_a", 32'(done_a), 1);
        check("done_b", 32'(done_b), 1);
        check("core_rst_n", 32'(crn_a), 1);
        check("no_error", 32'(err_a), 0);
        check("wr_cnt_a", 32'(wr_a - base_a), 32'(n));
        check("wr_cnt_b", 32'(wr_b - base_b), 32'(n));
        check("exp_left", 32'(exp_a.size() + exp_b.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_byte_ready", 32'(br_a), 0);
        check("rst_mem_we", 32'(we_a), 0);
        check("rst_mem_addr", addr_a, 0);
        check("rst_mem_wdata", wd_a, 0);
        check("rst_core_rst_n", 32'(crn_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_error", 32'(err_a), 0);
        check("rst_mem_addr_b", 32'(addr_b), 0);
    endtask

    task automatic rand_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
    endtask

    initial begin
        int base;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        prog.delete();
        prog.push_back(32'h0000_0013);
        prog.push_back(32'h0010_0093);
        rdy_mode = 0;
        load(2, 1, 0, 1);
        check("normal_last_addr", last_a_addr, 32'h0000_0104);
        check("normal_last_data", last_a_data, 32'h0010_0093);
        check("normal_last_b", 32'(last_b_addr), 32'h0000_00FC);

        pulse_start();
        @(negedge clk);
        check("restart_done", 32'(done_a), 0);
        check("restart_crn", 32'(crn_a), 0);
        check("restart_busy", 32'(busy_a), 1);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        load(2, 0, 3, 0);
        check("bp_last_data", last_a_data, 32'h0010_0093);

        rdy_mode = 2;
        noise = 1'b1;
        repeat (3) begin
            int n;
            n = $urandom_range(8, 1);
            rand_prog(n);
            load(n, 1, 2, 0);
        end
        noise = 1'b0;

        rdy_mode = 0;
        load(0, 1, 1, 0);

        pulse_start();
        @(negedge clk);
        check("err_restart_err", 32'(err_a), 0);
        check("err_restart_busy", 32'(busy_a), 1);
        @(posedge clk);
        #1;
        rand_prog(3);
        load(3, 0, 0, 0);
        check("wrap_last_b", 32'(last_b_addr), 32'h0000_0000);

        load(DEPTH + 1, 1, 0, 0);

        rand_prog(DEPTH);
        load(DEPTH, 1, 0, 0);
        check("full_last_a", last_a_addr, 32'h0000_04FC);
        check("full_last_b", 32'(last_b_addr), 32'h0000_00F4);

        pulse_start();
        send_word(32'd2, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        base = wr_a;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_nowr", 32'(wr_a - base), 0);
        check("midrst_idle", 32'(busy_a), 0);
        prog.delete();
        prog.push_back(32'h0000_0013);
        prog.push_back(32'h0010_0093);
        load(2, 1, 0, 0);

        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory that the fetch stage reads. Accepts a byte stream over a valid/ready handshake: a 4-byte little-endian word count, then the program words. Assembles the bytes into 32-bit words and writes them to consecutive byte addresses. Holds the fetch/core side in reset until a load has completed.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of mem_addr (byte address)
- DEPTH_WORDS, 256, maximum number of words a load may write
- BASE_ADDR, 0, byte address of the first written word (word-aligned)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR
- byte_valid  in  1  stream byte present
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts byte_data this cycle (transfer = byte_valid & byte_ready)
- mem_we  out  1  write request to instruction memory
- mem_addr  out  ADDR_WIDTH  write byte address
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepts the write this cycle (write = mem_we & mem_ready)
- core_rst_n  out  1  active-low reset to the fetch stage/core
- busy  out  1  high in LEN, DATA and WRITE
- done  out  1  high in DONE
- error  out  1  high in ERROR

## Operation
- States: IDLE, LEN, DATA, WRITE, DONE, ERROR.
- IDLE: byte_ready=0. start → LEN, clears the byte index, the word counter and the shift register.
- LEN: byte_ready=1. Four transfers form the count N. The first byte goes to bits [7:0] and the fourth to bits [31:24]. After the fourth byte:
  - N==0 or N>DEPTH_WORDS → ERROR.
  - Otherwise → DATA.
- DATA: byte_ready=1. Four transfers form a word, also little-endian. The fourth transfer → WRITE, with the word latched into mem_wdata.
- WRITE: byte_ready=0, mem_we=1.
  - mem_addr = BASE_ADDR + 4*i, where i is the 0-based word index. Arithmetic is ADDR_WIDTH bits and wraps.
  - mem_addr and mem_wdata are held stable until the write is accepted.
  - On mem_ready=1: i increments. If i+1==N → DONE, otherwise → DATA.
- DONE: core_rst_n=1, done=1, byte_ready=0.
- ERROR: error=1, core_rst_n=0, byte_ready=0.
- start in DONE or ERROR → LEN. done/error clear and core_rst_n drops to 0 on the same edge.
- start in LEN, DATA or WRITE is ignored.
- Bytes offered while byte_ready=0 are not consumed. Upstream must hold them.
- A stalled stream (byte_valid=0) pauses the load indefinitely. There is no timeout.

## Timing
- Reset (rst=0 at an edge) → IDLE. Reset values:
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - core_rst_n=0, busy=0, done=0, error=0
  - internal counters 0
- Reset mid-load abandons the partial word with no further write. Memory contents already written are not touched.
- All outputs are registered or decoded directly from state. No combinational path from byte_valid or mem_ready to any output.
- Byte transfers: one per cycle at full rate.
- The 4th data byte accepted at edge k gives mem_we=1 from cycle k+1.
- With mem_ready=1, the write completes at edge k+1 and byte_ready=1 again at k+2. Steady-state throughput is 4 bytes per 5 cycles.
- Last write accepted at edge m → done=1 and core_rst_n=1 from cycle m+1.
- LEN with a 4th byte at edge k → DATA or ERROR visible from cycle k+1.

## Test plan
- Normal load:
  - Stimulus: rst low 2 cycles; start; stream 02 00 00 00, 13 00 00 00, 93 00 10 00 at full rate, mem_ready=1.
  - Response: writes (BASE_ADDR+0, 0x00000013) and (BASE_ADDR+4, 0x00100093); then done=1 and core_rst_n=1; exactly 2 mem_we cycles.
- Backpressure:
  - Stimulus: same stream with byte_valid randomly gapped and mem_ready held 0 for 3 cycles on each write.
  - Response: identical writes; mem_addr/mem_wdata stable while mem_we=1 and mem_ready=0; no byte consumed during WRITE.
- Length errors:
  - Count 0 → error=1 with no mem_we.
  - Count DEPTH_WORDS+1 → error=1.
  - Count DEPTH_WORDS → DEPTH_WORDS writes, last at BASE_ADDR+4*(DEPTH_WORDS-1), then done=1.
- Reset mid-load:
  - Stimulus: rst=0 after 2 of 4 data bytes.
  - Response: next cycle all outputs at reset values; no write issued; a following start and full load succeeds.
- Start handling:
  - start pulses in LEN, DATA and WRITE have no effect.
  - start in DONE: core_rst_n=0 and done=0 on the next cycle; a second load completes.
  - start in ERROR: error clears and a new load completes.
- Address wrap:
  - Stimulus: ADDR_WIDTH=8, BASE_ADDR=0xF8, count 3.
  - Response: writes at 0xF8, 0xFC, 0x00.
